armleocpu_multiplier_iter: RTL
==============================

Name: armleocpu_multiplier_iter

Overview:
- Parametrised iterative multiplier; successor to the fixed 32x32 four-partial-product unit.
- Splits each factor into CHUNK-bit digits and accumulates one partial product per cycle.
- Supports per-operand signedness, i.e. RISC-V MUL/MULH/MULHSU/MULHU, plus abort.
- Sits beside the ALU in the execute stage; the divider follows the same handshake.

Parameters:
- WIDTH, 32, factor width in bits; must be a multiple of CHUNK.
- CHUNK, 16, digit width; one CHUNK x CHUNK unsigned multiply per cycle.
- Derived localparam D = WIDTH/CHUNK, digits per factor.
- Derived localparam N = D*D, number of partial products.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- valid  in  1  request; sampled only in IDLE.
- ready  out  1  high in IDLE only; a request is accepted in a cycle where valid && ready.
- factor0  in  WIDTH  first operand, sampled on accept.
- factor1  in  WIDTH  second operand, sampled on accept.
- factor0_signed  in  1  treat factor0 as two's complement; sampled on accept.
- factor1_signed  in  1  treat factor1 as two's complement; sampled on accept.
- kill  in  1  abort the in-flight operation.
- done  out  1  one-cycle pulse; result is valid while done is high.
- result  out  2*WIDTH  full product; holds its value until the next accept.

Behaviour:
- Reset: state=IDLE, ready=1, done=0, result=0, accumulator=0, digit counter=0. Reset overrides kill and valid, and aborts any in-flight operation silently.
- States: IDLE -> MUL -> DRAIN -> FIX -> IDLE.
- IDLE, on accept (cycle T):
  - neg0 = factor0_signed & factor0[WIDTH-1]; neg1 likewise for factor1.
  - Store magnitudes |factor0| and |factor1| as WIDTH-bit unsigned; -2^(WIDTH-1) maps to 2^(WIDTH-1) and needs no extra bit.
  - Store neg = neg0 ^ neg1. Clear accumulator and counter k. Go to MUL.
- MUL: k = 0..N-1.
  - i = k mod D, j = k / D.
  - Partial product = a_digit[i] * b_digit[j], width 2*CHUNK, shifted left by (i+j)*CHUNK.
  - Registered into an intermediate register; the accumulator adds the previous intermediate each cycle.
  - Going to DRAIN after k=N-1.
- DRAIN: accumulator += last intermediate.
- FIX: result <= neg ? (~acc + 1) : acc, truncated to 2*WIDTH; done=1 in this cycle's following edge output.
- Latency: done is high in cycle T+N+2 (T+6 for 32/16); ready returns in the same cycle as done.
- Back-to-back: valid may be held high; the next accept occurs in the done cycle at the earliest.
- Arithmetic:
  - All accumulation is modulo 2^(2*WIDTH); no overflow is possible for magnitudes.
  - Sign fix uses a two's complement negate of the full 2*WIDTH value.
- kill:
  - In MUL/DRAIN/FIX: next state IDLE, no done, result unchanged.
  - In IDLE: ignored.
  - kill with valid in IDLE: accept proceeds.
- kill in the done cycle: done already asserted, result kept.
- Operands changing after accept have no effect.

Optional Feature:
- ARMLEOCPU_MULTIPLIER_EARLY_OUT_EN: when defined, an accept with either factor == 0 goes directly to FIX with acc=0.
- In that case done is high at T+2 and result=0.
- Without the macro: fixed latency N+2 for all operands.

Decomposition:
- Package armleocpu_mul_pkg holds:
  - State encoding localparams STATE_IDLE/MUL/DRAIN/FIX.
  - D/N derivation function.
  - Sign-mode constants MODE_MUL/MULH/MULHSU/MULHU mapping to the signed flag pairs, for the decoder.
- One sub-module is natural: armleocpu_mul_digit_pp.
  - Combinational digit select, CHUNK multiply and shift from (a, b, k).
  - Keeps the FSM file free of the index arithmetic.

Test Plan:
- 0xFFFFFFFF x 0xFFFFFFFF, unsigned/unsigned -> result 0xFFFFFFFE00000001; done exactly at T+6; ready low in T+1..T+5.
- Same operands, signed/signed -> 0x0000000000000001. Signed/unsigned (MULHSU) -> 0xFFFFFFFF00000001.
- 0x80000000 x 0x80000000, signed/signed -> 0x4000000000000000; unsigned -> also 0x4000000000000000.
- Assert kill at T+2 -> no done pulse, ready=1 at T+3, result retains its previous value. A new accept at T+3 produces the correct product at T+9.
- valid held high with operands 7 x 6, then 0xFFFFFFFF(signed) x 3 -> done pulses 42 then 0xFFFFFFFFFFFFFFFD, with no idle gap beyond the accept cycle. Assert rst mid-MUL -> ready=1, done=0, result=0 next cycle.
- WIDTH=64, CHUNK=16 (N=16): random signed/unsigned pairs against a reference model, latency 18. With EARLY_OUT_EN: 0 x 0x1234 -> result 0 at T+2.

Source files
------------

// File: rtl/armleocpu_mul_pkg.sv
// Shared definitions for the iterative multiplier: FSM states, digit-count helpers
// and the RISC-V sign-mode pairs used by the decoder.
// Latency: n/a (package). Backpressure: n/a.
package armleocpu_mul_pkg;

    typedef enum logic [1:0] {
        STATE_IDLE  = 2'd0,
        STATE_MUL   = 2'd1,
        STATE_DRAIN = 2'd2,
        STATE_FIX   = 2'd3
    } state_t;

    // Digits per factor.
    function automatic int mul_digits(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Partial products per operation.
    function automatic int mul_pps(input int width, input int chunk);
        return mul_digits(width, chunk) * mul_digits(width, chunk);
    endfunction

    // Signedness flags of {factor0, factor1} for each RISC-V multiply flavour.
    typedef struct packed {
        logic factor0_signed;
        logic factor1_signed;
    } sign_mode_t;

    // MUL only keeps the low half, which does not depend on signedness.
    localparam sign_mode_t MODE_MUL    = '{factor0_signed: 1'b0, factor1_signed: 1'b0};
    localparam sign_mode_t MODE_MULH   = '{factor0_signed: 1'b1, factor1_signed: 1'b1};
    localparam sign_mode_t MODE_MULHSU = '{factor0_signed: 1'b1, factor1_signed: 1'b0};
    localparam sign_mode_t MODE_MULHU  = '{factor0_signed: 1'b0, factor1_signed: 1'b0};

endpackage

// File: rtl/armleocpu_mul_digit_pp.sv
// Digit partial product: selects a_i digit (k mod D) and b_i digit (k / D), multiplies
// them and shifts the product into place. Latency: combinational. Backpressure: none.
// Ports: a_i/b_i magnitudes, k_i partial-product index, pp_o shifted 2*WIDTH product.
import armleocpu_mul_pkg::*;

module armleocpu_mul_digit_pp #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 16,
    parameter int KW    = 2
) (
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic [KW-1:0]      k_i,
    output logic [2*WIDTH-1:0] pp_o
);

    localparam int D = mul_digits(WIDTH, CHUNK);

    int                 i_idx;
    int                 j_idx;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [2*CHUNK-1:0] prod;
    logic [2*WIDTH-1:0] ext;

    always_comb begin
        i_idx = int'(k_i) % D;
        j_idx = int'(k_i) / D;
        // Shift the wanted digit down to bit 0 rather than using a variable part-select.
        a_sh  = a_i >> (i_idx * CHUNK);
        b_sh  = b_i >> (j_idx * CHUNK);
        prod  = {{CHUNK{1'b0}}, a_sh[CHUNK-1:0]} * {{CHUNK{1'b0}}, b_sh[CHUNK-1:0]};
        ext   = '0;
        ext[2*CHUNK-1:0] = prod;
        pp_o  = ext << ((i_idx + j_idx) * CHUNK);
    end

endmodule

// File: rtl/armleocpu_multiplier_iter.sv
// Iterative WIDTHxWIDTH multiplier, one CHUNKxCHUNK digit product per cycle, signed/unsigned per operand.
// Latency: done high N+2 cycles after accept (2 cycles for a zero factor with ARMLEOCPU_MULTIPLIER_EARLY_OUT_EN).
// Backpressure: ready only in IDLE/done cycle; kill aborts silently; result held until next completion.
// Ports: clk, rst (sync, active high), valid/ready request handshake, factor0/factor1 with *_signed flags,
// kill abort, done one-cycle pulse, result 2*WIDTH product.
// Optional build macro: ARMLEOCPU_MULTIPLIER_EARLY_OUT_EN (zero factor skips the multiply loop).
import armleocpu_mul_pkg::*;

module armleocpu_multiplier_iter #(
    parameter int WIDTH = 32,   // must be a multiple of CHUNK
    parameter int CHUNK = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid,
    output logic               ready,
    input  logic [WIDTH-1:0]   factor0,
    input  logic [WIDTH-1:0]   factor1,
    input  logic               factor0_signed,
    input  logic               factor1_signed,
    input  logic               kill,
    output logic               done,
    output logic [2*WIDTH-1:0] result
);

    localparam int D  = mul_digits(WIDTH, CHUNK);
    localparam int N  = mul_pps(WIDTH, CHUNK);
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    state_t             state_q;
    logic               ready_q;
    logic               done_q;
    logic [2*WIDTH-1:0] result_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] inter_q;
    logic [KW-1:0]      k_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               neg_q;

    logic               neg0;
    logic               neg1;
    logic [WIDTH-1:0]   mag0;
    logic [WIDTH-1:0]   mag1;
    logic               zero_op;
    logic [2*WIDTH-1:0] pp;
    logic [2*WIDTH-1:0] acc_d;
    logic [2*WIDTH-1:0] result_d;

    // Magnitudes: -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude.
    assign neg0 = factor0_signed & factor0[WIDTH-1];
    assign neg1 = factor1_signed & factor1[WIDTH-1];
    assign mag0 = neg0 ? (~factor0 + 1'b1) : factor0;
    assign mag1 = neg1 ? (~factor1 + 1'b1) : factor1;

`ifdef ARMLEOCPU_MULTIPLIER_EARLY_OUT_EN
    assign zero_op = (factor0 == '0) || (factor1 == '0);
`else
    assign zero_op = 1'b0;
`endif

    armleocpu_mul_digit_pp #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK),
        .KW    (KW)
    ) u_pp (
        .a_i  (a_q),
        .b_i  (b_q),
        .k_i  (k_q),
        .pp_o (pp)
    );

    // The accumulator trails the partial-product register by one cycle; DRAIN adds the last one.
    assign acc_d    = acc_q + inter_q;
    assign result_d = neg_q ? (~acc_d + 1'b1) : acc_d;

    // STATE_FIX is the done cycle: the signed result was registered on the DRAIN edge,
    // and the unit is already ready for the next request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= STATE_IDLE;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            result_q <= '0;
            acc_q    <= '0;
            inter_q  <= '0;
            k_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                STATE_IDLE, STATE_FIX: begin
                    if (valid) begin
                        a_q     <= mag0;
                        b_q     <= mag1;
                        neg_q   <= neg0 ^ neg1;
                        acc_q   <= '0;
                        inter_q <= '0;
                        k_q     <= '0;
                        ready_q <= 1'b0;
                        // A zero factor goes straight to the final add with an empty accumulator.
                        state_q <= zero_op ? STATE_DRAIN : STATE_MUL;
                    end else begin
                        ready_q <= 1'b1;
                        state_q <= STATE_IDLE;
                    end
                end
                STATE_MUL: begin
                    if (kill) begin
                        ready_q <= 1'b1;
                        state_q <= STATE_IDLE;
                    end else begin
                        inter_q <= pp;
                        acc_q   <= acc_d;
                        k_q     <= k_q + 1'b1;
                        if (k_q == K_LAST) begin
                            state_q <= STATE_DRAIN;
                        end
                    end
                end
                STATE_DRAIN: begin
                    if (kill) begin
                        ready_q <= 1'b1;
                        state_q <= STATE_IDLE;
                    end else begin
                        acc_q    <= acc_d;
                        result_q <= result_d;
                        done_q   <= 1'b1;
                        ready_q  <= 1'b1;
                        state_q  <= STATE_FIX;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= STATE_IDLE;
                end
            endcase
        end
    end

    assign ready  = ready_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
